// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 layer controllers: FSM state encoding
// and the fully connected layer shapes.
package lenet_pkg;

    // One-hot FSM encoding; ST_BIAS is only reachable when the bias build is selected.
    typedef enum logic [6:0] {
        ST_IDLE    = 7'b0000001,
        ST_RUN     = 7'b0000010,
        ST_DRAIN   = 7'b0000100,
        ST_WRITE   = 7'b0001000,
        ST_DONE    = 7'b0010000,
        ST_RELEASE = 7'b0100000,
        ST_BIAS    = 7'b1000000
    } fc_state_e;

    localparam int FC1_N_IN  = 400;
    localparam int FC1_N_OUT = 120;
    localparam int FC2_N_IN  = 120;
    localparam int FC2_N_OUT = 84;
    localparam int FC3_N_IN  = 84;
    localparam int FC3_N_OUT = 10;

    // Cycles spent per output neuron: RUN beats, DRAIN, WRITE and optional BIAS.
    function automatic int fc_neuron_cycles(input int n_in, input bit bias_en);
        return n_in + 2 + (bias_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/addr_gen.sv
// Address counters for one FC layer: input index j, neuron index o and a
// running weight address. The j and w counters lead the issued address by
// one beat; j_tc reports that the last step wrapped j (final input of a neuron).
module addr_gen
    import lenet_pkg::*;
#(
    parameter int N_IN  = FC1_N_IN,
    parameter int N_OUT = FC1_N_OUT,
    parameter int IA_W  = $clog2(N_IN),
    parameter int WA_W  = $clog2(N_IN*N_OUT),
    parameter int OA_W  = $clog2(N_OUT)
)
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_j_step,
    input  logic            i_o_step,
    output logic [IA_W-1:0] o_j,
    output logic [WA_W-1:0] o_w,
    output logic [OA_W-1:0] o_o,
    output logic            o_j_tc,
    output logic            o_o_last
);

    localparam logic [IA_W-1:0] J_LAST = IA_W'(N_IN - 1);
    localparam logic [OA_W-1:0] O_LAST = OA_W'(N_OUT - 1);

    logic [IA_W-1:0] r_j;
    logic [WA_W-1:0] r_w;
    logic [OA_W-1:0] r_o;
    logic            r_j_tc;
    logic            w_o_last;

    assign w_o_last = (r_o == O_LAST);

    // Input index with wrap, plus the wrapped-on-last-step flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_j    <= '0;
            r_j_tc <= 1'b0;
        end else if (i_j_step) begin
            if (r_j == J_LAST) begin
                r_j    <= '0;
                r_j_tc <= 1'b1;
            end else begin
                r_j    <= r_j + IA_W'(1);
                r_j_tc <= 1'b0;
            end
        end
    end

    // Weight address runs continuously across neurons, equal to o*N_IN+j.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_w <= '0;
        end else if (i_j_step) begin
            r_w <= r_w + WA_W'(1);
        end
    end

    // Output neuron index with wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_o <= '0;
        end else if (i_o_step) begin
            r_o <= w_o_last ? '0 : r_o + OA_W'(1);
        end
    end

    assign o_j      = r_j;
    assign o_w      = r_w;
    assign o_o      = r_o;
    assign o_j_tc   = r_j_tc;
    assign o_o_last = w_o_last;

endmodule

// File: rtl/fc_layer_ctrl.sv
// Engine controller for one fully connected layer. Walks every output neuron,
// streams activation/weight addresses, sequences the MAC and writes results.
// Optional feature macro: FC_BIAS_EN adds a BIAS beat per neuron with
// b_rd_en/b_addr/mac_ld ports; mac_clr is then tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for en; counters at zero
// BIAS    | bias read for neuron o (bias build only)
// RUN     | N_IN read beats for neuron o, j = 0..N_IN-1
// DRAIN   | last product accumulated, no read
// WRITE   | accumulator written to output buffer at o
// DONE    | one-cycle completion pulse
// RELEASE | layer finished; wait for en to drop before re-arming
module fc_layer_ctrl
    import lenet_pkg::*;
#(
    parameter int N_IN  = FC1_N_IN,
    parameter int N_OUT = FC1_N_OUT,
    parameter int IA_W  = $clog2(N_IN),
    parameter int WA_W  = $clog2(N_IN*N_OUT),
    parameter int OA_W  = $clog2(N_OUT)
)
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    output logic            o_done,
    output logic            o_rd_en,
    output logic [IA_W-1:0] o_in_addr,
    output logic [WA_W-1:0] o_w_addr,
    output logic            o_mac_clr,
    output logic            o_mac_acc,
    output logic            o_out_we,
    output logic [OA_W-1:0] o_out_addr,
`ifdef FC_BIAS_EN
    output logic            o_b_rd_en,
    output logic [OA_W-1:0] o_b_addr,
    output logic            o_mac_ld,
`endif
    output logic            o_busy
);

    fc_state_e       r_state;
    logic            r_done;
    logic            r_rd_en;
    logic [IA_W-1:0] r_in_addr;
    logic [WA_W-1:0] r_w_addr;
    logic            r_mac_acc;
    logic            r_out_we;
    logic [OA_W-1:0] r_out_addr;
    logic            r_busy;
`ifdef FC_BIAS_EN
    logic            r_b_rd_en;
    logic [OA_W-1:0] r_b_addr;
    logic            r_mac_ld;
`else
    logic            r_mac_clr;
`endif

    logic            w_abort;
    logic            w_finish;
    logic            w_issue;
    logic            w_o_step;
    logic            w_cnt_clr;
    logic [IA_W-1:0] w_j;
    logic [WA_W-1:0] w_w;
    logic [OA_W-1:0] w_o;
    logic            w_j_tc;
    logic            w_o_last;

    addr_gen #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .IA_W  (IA_W),
        .WA_W  (WA_W),
        .OA_W  (OA_W)
    ) u_addr_gen (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_cnt_clr),
        .i_j_step (w_issue),
        .i_o_step (w_o_step),
        .o_j      (w_j),
        .o_w      (w_w),
        .o_o      (w_o),
        .o_j_tc   (w_j_tc),
        .o_o_last (w_o_last)
    );

    // Counter commands decoded from the current state; w_issue marks an edge
    // that launches a read beat with the counters' current j/w.
    always_comb begin
        w_abort  = !i_en && ((r_state == ST_RUN) || (r_state == ST_DRAIN) ||
                             (r_state == ST_WRITE) || (r_state == ST_BIAS));
        w_finish = i_en && (r_state == ST_WRITE) && w_o_last;
        w_o_step = i_en && (r_state == ST_WRITE) && !w_o_last;
`ifdef FC_BIAS_EN
        w_issue  = i_en && ((r_state == ST_BIAS) ||
                            ((r_state == ST_RUN) && !w_j_tc));
`else
        w_issue  = i_en && ((r_state == ST_IDLE) ||
                            ((r_state == ST_RUN) && !w_j_tc) || w_o_step);
`endif
        w_cnt_clr = w_abort || w_finish;
    end

    // State transitions and registered outputs; outputs default to 0 each beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_in_addr  <= '0;
            r_w_addr   <= '0;
            r_mac_acc  <= 1'b0;
            r_out_we   <= 1'b0;
            r_out_addr <= '0;
            r_busy     <= 1'b0;
`ifdef FC_BIAS_EN
            r_b_rd_en  <= 1'b0;
            r_b_addr   <= '0;
            r_mac_ld   <= 1'b0;
`else
            r_mac_clr  <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_in_addr  <= '0;
            r_w_addr   <= '0;
            r_out_we   <= 1'b0;
            r_out_addr <= '0;
            r_busy     <= 1'b1;
            // Accumulate one beat after each read, never on the way back to IDLE.
            r_mac_acc  <= r_rd_en && !w_abort;
`ifdef FC_BIAS_EN
            r_b_rd_en  <= 1'b0;
            r_b_addr   <= '0;
            r_mac_ld   <= 1'b0;
`else
            r_mac_clr  <= 1'b0;
`endif

            if (w_issue) begin
                r_rd_en   <= 1'b1;
                r_in_addr <= w_j;
                r_w_addr  <= w_w;
`ifdef FC_BIAS_EN
                r_mac_ld  <= (w_j == '0);
`else
                r_mac_clr <= (w_j == '0);
`endif
            end

            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_en) begin
`ifdef FC_BIAS_EN
                            r_state   <= ST_BIAS;
                            r_b_rd_en <= 1'b1;
                            r_b_addr  <= w_o;
`else
                            r_state   <= ST_RUN;
`endif
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end
`ifdef FC_BIAS_EN
                    ST_BIAS: begin
                        r_state <= ST_RUN;
                    end
`endif
                    ST_RUN: begin
                        if (w_j_tc) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        r_state    <= ST_WRITE;
                        r_out_we   <= 1'b1;
                        r_out_addr <= w_o;
                    end
                    ST_WRITE: begin
                        if (w_o_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
`ifdef FC_BIAS_EN
                            r_state   <= ST_BIAS;
                            r_b_rd_en <= 1'b1;
                            r_b_addr  <= w_o + OA_W'(1);
`else
                            r_state   <= ST_RUN;
`endif
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        if (!i_en) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_done     = r_done;
    assign o_rd_en    = r_rd_en;
    assign o_in_addr  = r_in_addr;
    assign o_w_addr   = r_w_addr;
    assign o_mac_acc  = r_mac_acc;
    assign o_out_we   = r_out_we;
    assign o_out_addr = r_out_addr;
    assign o_busy     = r_busy;
`ifdef FC_BIAS_EN
    assign o_mac_clr  = 1'b0;
    assign o_b_rd_en  = r_b_rd_en;
    assign o_b_addr   = r_b_addr;
    assign o_mac_ld   = r_mac_ld;
`else
    assign o_mac_clr  = r_mac_clr;
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl (N_IN=4; N_OUT=3, or 2 with FC_BIAS_EN).
// Each beat pushes the expected output vector for the coming cycle and pops
// it for comparison half a clock after the edge.
`timescale 1ns/1ps
module tb_fc_layer_ctrl;

    localparam int N_IN = 4;
`ifdef FC_BIAS_EN
    localparam int N_OUT = 2;
    localparam int BIAS  = 1;
`else
    localparam int N_OUT = 3;
    localparam int BIAS  = 0;
`endif
    localparam int IA_W   = $clog2(N_IN);
    localparam int WA_W   = $clog2(N_IN*N_OUT);
    localparam int OA_W   = $clog2(N_OUT);
    localparam int P      = N_IN + 2 + BIAS;
    localparam int DONE_K = 1 + N_OUT*P;

    typedef struct packed {
        logic            done;
        logic            rd_en;
        logic [IA_W-1:0] in_addr;
        logic [WA_W-1:0] w_addr;
        logic            mac_clr;
        logic            mac_acc;
        logic            out_we;
        logic [OA_W-1:0] out_addr;
        logic            busy;
        logic            b_rd_en;
        logic [OA_W-1:0] b_addr;
        logic            mac_ld;
    } out_t;

    logic            clk;
    logic            rst;
    logic            en;
    logic            done;
    logic            rd_en;
    logic [IA_W-1:0] in_addr;
    logic [WA_W-1:0] w_addr;
    logic            mac_clr;
    logic            mac_acc;
    logic            out_we;
    logic [OA_W-1:0] out_addr;
    logic            busy;
`ifdef FC_BIAS_EN
    logic            b_rd_en;
    logic [OA_W-1:0] b_addr;
    logic            mac_ld;
`endif

    out_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    fc_layer_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .o_done     (done),
        .o_rd_en    (rd_en),
        .o_in_addr  (in_addr),
        .o_w_addr   (w_addr),
        .o_mac_clr  (mac_clr),
        .o_mac_acc  (mac_acc),
        .o_out_we   (out_we),
        .o_out_addr (out_addr),
`ifdef FC_BIAS_EN
        .o_b_rd_en  (b_rd_en),
        .o_b_addr   (b_addr),
        .o_mac_ld   (mac_ld),
`endif
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t s = '0;
        s.done     = done;
        s.rd_en    = rd_en;
        s.in_addr  = in_addr;
        s.w_addr   = w_addr;
        s.mac_clr  = mac_clr;
        s.mac_acc  = mac_acc;
        s.out_we   = out_we;
        s.out_addr = out_addr;
        s.busy     = busy;
`ifdef FC_BIAS_EN
        s.b_rd_en  = b_rd_en;
        s.b_addr   = b_addr;
        s.mac_ld   = mac_ld;
`endif
        return s;
    endfunction

    // Expected outputs in cycle k after en is first sampled, en held high throughout.
    function automatic out_t model(input int k);
        out_t e = '0;
        int   o;
        int   p;
        if (k >= 1 && k < DONE_K) begin
            o = (k - 1) / P;
            p = (k - 1) % P - BIAS;
            e.busy = 1'b1;
            if (p < 0) begin
                e.b_rd_en = 1'b1;
                e.b_addr  = OA_W'(o);
            end else if (p < N_IN) begin
                e.rd_en   = 1'b1;
                e.in_addr = IA_W'(p);
                e.w_addr  = WA_W'(o*N_IN + p);
                if (p == 0) begin
                    if (BIAS != 0) e.mac_ld = 1'b1;
                    else           e.mac_clr = 1'b1;
                end else begin
                    e.mac_acc = 1'b1;
                end
            end else if (p == N_IN) begin
                e.mac_acc = 1'b1;
            end else begin
                e.out_we   = 1'b1;
                e.out_addr = OA_W'(o);
            end
        end else if (k == DONE_K) begin
            e.done = 1'b1;
            e.busy = 1'b1;
        end else if (k > DONE_K) begin
            e.busy = 1'b1;
        end
        return e;
    endfunction

    // Drive inputs for the next edge, then compare the resulting cycle.
    task automatic beat(input logic en_v, input logic rst_v, input out_t exp_v,
                        input string tag, input int k);
        out_t e;
        out_t o;
        en  = en_v;
        rst = rst_v;
        exp_q.push_back(exp_v);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        o = sample();
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
        end
    endtask

    initial begin
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        beat(1'b0, 1'b1, '0, "reset", 0);
        beat(1'b0, 1'b0, '0, "idle", 0);

        // Normal run, en held until done, then held 5 more cycles in RELEASE
        for (int k = 1; k <= DONE_K; k++) beat(1'b1, 1'b0, model(k), "run1", k);
        for (int k = DONE_K + 1; k <= DONE_K + 5; k++) beat(1'b1, 1'b0, model(k), "hold", k);
        beat(1'b0, 1'b0, '0, "rel_idle", 0);

        // One low cycle then a full restart
        for (int k = 1; k <= DONE_K; k++) beat(1'b1, 1'b0, model(k), "run2", k);
        beat(1'b0, 1'b0, model(DONE_K + 1), "run2_rel", DONE_K + 1);
        beat(1'b0, 1'b0, '0, "run2_idle", 0);

        // Abort: en dropped in cycle 8
        for (int k = 1; k <= 8; k++) beat(1'b1, 1'b0, model(k), "abort_pre", k);
        for (int k = 9; k <= 14; k++) beat(1'b0, 1'b0, '0, "abort", k);

        // Reset asserted in cycle 10 with en still high
        for (int k = 1; k <= 10; k++) beat(1'b1, 1'b0, model(k), "rst_pre", k);
        beat(1'b1, 1'b1, '0, "rst_mid", 11);
        beat(1'b0, 1'b0, '0, "rst_idle", 12);

        // Fresh run after reset reproduces the normal run
        for (int k = 1; k <= DONE_K; k++) beat(1'b1, 1'b0, model(k), "run3", k);
        beat(1'b0, 1'b0, model(DONE_K + 1), "run3_rel", DONE_K + 1);
        beat(1'b0, 1'b0, '0, "run3_idle", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Layer-side engine controller for one fully connected LeNet-5 layer (FC1/FC2/FC3). It answers the top-level sequencer's per-layer `en`/`done` handshake: on `en` it walks every output neuron. For each neuron it streams input-activation and weight addresses to the buffers, drives the MAC clear/accumulate strobes, and writes each neuron result to the output buffer. It pulses `done` when the layer is complete. Each FC layer gets one instance, parameterised by that layer's shape.

## Interface
Parameters:
- `N_IN`, 400, input activations per neuron (≥2)
- `N_OUT`, 120, output neurons (≥1)
- `IA_W`, `$clog2(N_IN)`, input address width
- `WA_W`, `$clog2(N_IN*N_OUT)`, weight address width
- `OA_W`, `$clog2(N_OUT)`, output address width

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: reset is synchronous and active-high
- `en` in 1: layer enable from the sequencer (level)
- `done` out 1: one-cycle completion pulse
- `rd_en` out 1: read strobe to input and weight buffers (1-cycle read latency)
- `in_addr` out IA_W: input activation address
- `w_addr` out WA_W: weight address
- `mac_clr` out 1: clear accumulator at this edge
- `mac_acc` out 1: accumulate buffer data at this edge
- `out_we` out 1: write accumulator to output buffer
- `out_addr` out OA_W: output neuron index
- `busy` out 1: high in any state except IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE, RELEASE (one-hot).
- IDLE: when `en`=1 at an edge, go to RUN with neuron counter o=0 and input counter j=0.
- RUN (N_IN cycles per neuron): `rd_en`=1, `in_addr`=j, `w_addr`=o*N_IN+j. The weight address is kept as a running counter, not a multiplier.
  - `mac_clr`=1 when j=0.
  - After j=N_IN-1, go to DRAIN.
- `mac_acc` is `rd_en` delayed one cycle, suppressed in IDLE. It is high for RUN cycles j=1..N_IN-1 and for the DRAIN cycle.
- DRAIN (1 cycle): `rd_en`=0. The last product is accumulated.
- WRITE (1 cycle): `out_we`=1, `out_addr`=o.
  - If o=N_OUT-1, go to DONE.
  - Otherwise go to RUN with o+1 and j=0.
- DONE (1 cycle): `done`=1. Then go to RELEASE.
- RELEASE: wait for `en`=0, then go to IDLE. `en` still high here never restarts the layer.
- Abort: `en`=0 in RUN, DRAIN or WRITE forces IDLE at the next edge. The output buffer is not written and `done` is not pulsed.
- Reset: FSM goes to IDLE and all counters go to 0. All outputs read 0 (`done`, `rd_en`, `mac_clr`, `mac_acc`, `out_we`, `busy`, and all addresses).
- Addresses are 0 whenever `rd_en`/`out_we` are low.

## Timing
- Let `en` first be sampled at edge E0; cycle k is the k-th cycle after E0.
- Neuron o occupies RUN cycles 1+o*(N_IN+2) … N_IN+o*(N_IN+2). Its DRAIN and WRITE cycles follow directly.
- `done` is high in cycle 1+N_OUT*(N_IN+2).
- Per-neuron cost is N_IN+2 cycles; there is no stall input.
- `mac_clr` and the first `rd_en` of a neuron coincide. The first `mac_acc` falls one cycle later, so clearing and accumulating never overlap.
- A restart needs at least one cycle of `en`=0 after `done`.

## Configuration
- `FC_BIAS_EN` defined:
  - A BIAS state (1 cycle) precedes each neuron's RUN, driving added ports `b_rd_en`=1 and `b_addr`=o (width OA_W).
  - The added output `mac_ld` replaces `mac_clr`: it is asserted in RUN j=0 and loads the bias into the accumulator.
  - `mac_clr` is tied 0.
  - Per-neuron cost becomes N_IN+3 cycles, so `done` is high at 1+N_OUT*(N_IN+3).
- `FC_BIAS_EN` undefined: no BIAS state, and none of `b_rd_en`, `b_addr` or `mac_ld` exist.

## Structure
- Shared package `lenet_pkg` holds:
  - the FSM state encoding as an enum/localparams;
  - the per-layer shape constants FC1 400×120, FC2 120×84, FC3 84×10.
- Sub-module `addr_gen` holds the o/j/weight counters with wrap and terminal-count flags. The FSM stays in `fc_layer_ctrl`.

## Test plan
- Normal run, N_IN=4, N_OUT=3, `en` held until `done`:
  - `done` is a single pulse in cycle 19.
  - `out_we` fires in cycles 6, 12 and 18 with `out_addr` 0, 1, 2.
  - `w_addr` sequence is 0..11.
- Accumulate sequencing, same configuration:
  - `mac_clr` in cycles 1, 7 and 13.
  - `mac_acc` high in cycles 2–5, 8–11 and 14–17.
  - `mac_clr` and `mac_acc` are never high together.
- `en` held high 5 cycles after `done`: no new `rd_en`. `en`=0 for 1 cycle then 1 again: a full restart, with `done` 19 cycles later.
- Abort: drop `en` in cycle 8 → IDLE at cycle 9. No `done`, no further `out_we`.
- `rst` asserted in cycle 10: every output is 0 next cycle. A fresh `en` then reproduces the normal-run scenario exactly.
- `FC_BIAS_EN`, N_IN=4, N_OUT=2:
  - `b_rd_en` in cycles 1 and 8 (`b_addr` 0, 1).
  - `mac_ld` in cycles 2 and 9.
  - `done` in cycle 15.
